// File: rtl/dm_access_arbiter.sv
// Two-port round-robin arbiter in front of a single-port data memory.
// Each transaction is IDLE (grant) -> ACCESS (memory cycle) -> RESP (rvalid pulse).
module dm_access_arbiter #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic              m0_byte,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_gnt,
  output logic              m0_rvalid,
  output logic [DATA_W-1:0] m0_rdata,
  output logic              m0_err,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic              m1_byte,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_gnt,
  output logic              m1_rvalid,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              m1_err,
  output logic              dm_wren,
  output logic              dm_wrbyte,
  output logic [ADDR_W-1:0] dm_addr,
  output logic [DATA_W-1:0] dm_din,
  input  logic [DATA_W-1:0] dm_dout,
  input  logic [7:0]        dm_bytedout
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_RESP   = 2'd2;

  // Highest address at which a full word still fits inside the memory.
  localparam logic [ADDR_W-1:0] MAX_WORD = ADDR_W'((2 ** ADDR_W) - 4);

  logic [1:0]        state_q, state_d;
  logic              ptr_q, ptr_d;
  logic              port_q, port_d;
  logic              we_q, we_d;
  logic              byte_q, byte_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata0_q, rdata1_q;
  logic              err0_q, err1_q;
  logic              in_access, err_w;
  logic [DATA_W-1:0] resp_w;

  assign in_access = (state_q == S_ACCESS);
  assign err_w     = ~byte_q & (addr_q > MAX_WORD);

  // Ties go to the pointer; a lone requester wins regardless of it.
  assign m0_gnt = (state_q == S_IDLE) & m0_req & (~m1_req | ~ptr_q);
  assign m1_gnt = (state_q == S_IDLE) & m1_req & (~m0_req |  ptr_q);

  assign dm_wren   = in_access & we_q & ~err_w;
  assign dm_wrbyte = in_access & byte_q;
  assign dm_addr   = addr_q;
  assign dm_din    = wdata_q;

  assign m0_rvalid = (state_q == S_RESP) & ~port_q;
  assign m1_rvalid = (state_q == S_RESP) &  port_q;
  assign m0_rdata  = rdata0_q;
  assign m1_rdata  = rdata1_q;
  assign m0_err    = err0_q;
  assign m1_err    = err1_q;

  always_comb begin
    resp_w = '0;
    if (!we_q && !err_w)
      resp_w = byte_q ? {{(DATA_W-8){1'b0}}, dm_bytedout} : dm_dout;
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    port_d  = port_q;
    we_d    = we_q;
    byte_d  = byte_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    case (state_q)
      S_IDLE: begin
        if (m0_gnt || m1_gnt) begin
          state_d = S_ACCESS;
          port_d  = m1_gnt;
          ptr_d   = ~m1_gnt;
          we_d    = m1_gnt ? m1_we    : m0_we;
          byte_d  = m1_gnt ? m1_byte  : m0_byte;
          addr_d  = m1_gnt ? m1_addr  : m0_addr;
          wdata_d = m1_gnt ? m1_wdata : m0_wdata;
        end
      end
      S_ACCESS: state_d = S_RESP;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      ptr_q    <= 1'b0;
      port_q   <= 1'b0;
      we_q     <= 1'b0;
      byte_q   <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata0_q <= '0;
      rdata1_q <= '0;
      err0_q   <= 1'b0;
      err1_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      port_q  <= port_d;
      we_q    <= we_d;
      byte_q  <= byte_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      // Response lands in the owning port's register and holds until its next transaction.
      if (in_access) begin
        if (port_q) begin
          rdata1_q <= resp_w;
          err1_q   <= err_w;
        end else begin
          rdata0_q <= resp_w;
          err0_q   <= err_w;
        end
      end
    end
  end

endmodule

// File: doc/dm_access_arbiter.md
DM_ACCESS_ARBITER -- requirements
Module: dm_access_arbiter

Interface
REQ-001 Parameter: ADDR_W, 12, byte-address width of the shared data memory (4096 bytes).
REQ-002 Parameter: DATA_W, 32, word width; fixed at 32 in this revision.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 m0_req/m1_req  input  1  access request from port 0 (core) / port 1 (DMA/debug); held until granted.
REQ-006 mX_we  input  1  1 = write, 0 = read.
REQ-007 mX_byte  input  1  1 = byte access, 0 = word access.
REQ-008 mX_addr  input  ADDR_W  byte address.
REQ-009 mX_wdata  input  32  write data; byte writes use [7:0].
REQ-010 mX_gnt  output  1  one-cycle pulse: request accepted this cycle.
REQ-011 mX_rvalid  output  1  one-cycle pulse: transaction complete, mX_rdata/mX_err valid.
REQ-012 mX_rdata  output  32  read data; byte reads zero-extended.
REQ-013 mX_err  output  1  out-of-range word access, qualified by mX_rvalid.
REQ-014 dm_wren, dm_wrbyte  output  1 each  memory write enable / byte-write select.
REQ-015 dm_addr  output  ADDR_W; dm_din  output  32  memory address / write data.
REQ-016 dm_dout  input  32; dm_bytedout  input  8  combinational memory read data (word / byte at dm_addr).

Function
REQ-017 FSM states: IDLE, ACCESS, RESP; encoding free.
REQ-018 IDLE: if any request is present, assert gnt combinationally to exactly one port, latch its we/byte/addr/wdata and its port id, go to ACCESS.
REQ-019 Arbitration: round-robin; priority pointer starts at port 0 and moves to the other port after every grant.
REQ-020 Single requester is granted regardless of the pointer; no grant when no request.
REQ-021 ACCESS (one cycle): dm_addr/dm_din/dm_wrbyte come from latched fields; dm_wren = latched we AND NOT err.
REQ-022 Error condition: word access (byte=0) with addr > 2^ADDR_W-4 (i.e. > 4092); no memory write occurs, rdata = 0.
REQ-023 Read in ACCESS: capture dm_dout (word) or {24'b0, dm_bytedout} (byte) into the response register at the end of the cycle.
REQ-024 Write in ACCESS: the memory commits on the ACCESS-ending edge; the response register keeps rdata = 0.
REQ-025 RESP (one cycle): pulse rvalid and drive rdata/err to the latched port only; go to IDLE.
REQ-026 Latency: request seen at cycle N -> gnt in N, memory access in N+1, rvalid in N+2; next grant no earlier than N+3.
REQ-027 Outside ACCESS: dm_wren = 0, dm_wrbyte = 0; dm_addr/dm_din hold their last values.
REQ-028 mX_rdata/mX_err hold their values between rvalid pulses; the non-selected port sees rvalid = 0.
REQ-029 Simultaneous requests in IDLE: the pointer decides; the loser keeps its req asserted and is served next.
REQ-030 A request that arrives or deasserts while not in IDLE is ignored until IDLE.

Reset
REQ-031 rst_n low -> immediately: state IDLE, pointer = port 0, all gnt/rvalid/err/dm_wren/dm_wrbyte = 0, dm_addr = 0, dm_din = 0, rdata = 0.
REQ-032 Reset during ACCESS: dm_wren drops asynchronously; no write commits; no rvalid is issued for the aborted transaction.

Verification
REQ-033 m0 word write addr 0x010 data 0xDEADBEEF -> gnt0 at N, dm_wren=1 with dm_addr=0x010 at N+1, rvalid0 at N+2 with err=0; a following m0 word read of 0x010 returns 0xDEADBEEF.
REQ-034 m1 byte read of 0x011 after REQ-033 -> rdata1 = 0x000000BE, rvalid1 only.
REQ-035 m0 and m1 both request continuously from reset -> grants alternate 0,1,0,1 every 3 cycles.
REQ-036 m0 word write at 0xFFD -> rvalid0 with err0=1, dm_wren never 1; a byte write at 0xFFF succeeds with err=0.
REQ-037 rst_n pulled low mid-ACCESS of a write to 0x020 -> dm_wren=0 at once, memory at 0x020 unchanged, no rvalid; after release the first grant goes to m0.
